// File: rtl/axi_bridge_pkg.sv
// Shared encodings, AXI constants and burst-shape helpers for the cache-to-AXI3 bridge.
package axi_bridge_pkg;

    typedef enum logic [2:0] {
        TYPE_BYTE = 3'b000,
        TYPE_HALF = 3'b001,
        TYPE_WORD = 3'b010,
        TYPE_LINE = 3'b100
    } req_type_e;

    typedef enum logic {
        AR_IDLE,
        AR_SEND
    } ar_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } w_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'd2;

    function automatic logic is_line(input logic [2:0] t);
        return t == TYPE_LINE;
    endfunction

    function automatic logic [2:0] ax_size(input logic [2:0] t);
        return is_line(t) ? SIZE_WORD : {1'b0, t[1:0]};
    endfunction

    function automatic logic [7:0] ax_len(input logic [2:0] t, input int unsigned words);
        return is_line(t) ? 8'(words - 1) : 8'd0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last advanced winner.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d, win;
    logic [PW:0]   idx;
    logic          found;

    always_comb begin
        grant_o = '0;
        win     = ptr_q;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
            if (!found && req_i[idx[PW-1:0]]) begin
                found                 = 1'b1;
                win                   = idx[PW-1:0];
                grant_o[idx[PW-1:0]]  = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (advance_i && found) ptr_d = (win == PW'(N - 1)) ? '0 : win + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/axi_cache_bridge.sv
// Cache-to-AXI3 bridge: round-robin reads with per-requester single outstanding burst, serialised writes.
// Optional AXI_BRIDGE_PERF_CNT_EN builds the rd/wr/stall performance counters; otherwise they read 0.
module axi_cache_bridge
    import axi_bridge_pkg::*;
#(
    parameter int unsigned NUM_RD     = 3,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LINE_OFF   = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [3*NUM_RD-1:0]      rd_type,
    input  logic [32*NUM_RD-1:0]     rd_addr,
    output logic [NUM_RD-1:0]        rd_rdy,
    output logic [NUM_RD-1:0]        ret_valid,
    output logic                     ret_last,
    output logic [31:0]              ret_data,
    input  logic                     wr_req,
    input  logic [2:0]               wr_type,
    input  logic [31:0]              wr_addr,
    input  logic [3:0]               wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    output logic                     wr_rdy,
    output logic [3:0]               arid,
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic [1:0]               arlock,
    output logic [3:0]               arcache,
    output logic [2:0]               arprot,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [3:0]               rid,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [3:0]               awid,
    output logic [31:0]              awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic [1:0]               awlock,
    output logic [3:0]               awcache,
    output logic [2:0]               awprot,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [3:0]               wid,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic [3:0]               bid,
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready,
    output logic [31:0]              perf_rd_cnt,
    output logic [31:0]              perf_wr_cnt,
    output logic [31:0]              perf_stall_cnt
);
    localparam int unsigned WIDX  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int unsigned TAG_W = 32 - LINE_OFF;

    ar_state_e          ar_state_q, ar_state_d;
    logic [3:0]         ar_id_q, ar_id_d;
    logic [31:0]        ar_addr_q, ar_addr_d;
    logic [2:0]         ar_type_q, ar_type_d;
    logic [NUM_RD-1:0]  rd_busy_q, rd_busy_d;
    w_state_e           w_state_q, w_state_d;
    logic [7:0]         w_cnt_q, w_cnt_d;
    logic [31:0]        w_addr_q;
    logic [2:0]         w_type_q;
    logic [3:0]         w_strb_q;
    logic [31:0]        w_words_q [LINE_WORDS];

    logic               w_accept, w_inflight, ar_idle, ar_accept, ar_hs;
    logic [NUM_RD-1:0]  hazard, eligible, grant;
    logic [3:0]         gnt_id;
    logic [31:0]        gnt_addr;
    logic [2:0]         gnt_type;
    logic               unused_in;

    assign unused_in = ^{rresp, bid, bresp};

    assign wr_rdy     = aresetn && (w_state_q == W_IDLE);
    assign w_accept   = wr_rdy && wr_req;
    assign w_inflight = (w_state_q != W_IDLE);

    // A write accepted this cycle also blocks reads to its line, so the write wins a same-cycle race.
    always_comb begin
        hazard = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            hazard[i] = (w_inflight && rd_addr[32*i + LINE_OFF +: TAG_W] == w_addr_q[31:LINE_OFF])
                     || (w_accept   && rd_addr[32*i + LINE_OFF +: TAG_W] == wr_addr[31:LINE_OFF]);
        end
    end

    assign eligible  = rd_req & ~rd_busy_q & ~hazard;
    assign ar_idle   = aresetn && (ar_state_q == AR_IDLE);
    assign rd_rdy    = ar_idle ? grant : '0;
    assign ar_accept = ar_idle && (|grant);
    assign ar_hs     = arvalid && arready;

    rr_arbiter #(.N(NUM_RD)) u_rr (
        .clk       (aclk),
        .rst_n     (aresetn),
        .req_i     (eligible),
        .advance_i (ar_accept),
        .grant_o   (grant)
    );

    always_comb begin
        gnt_id   = '0;
        gnt_addr = '0;
        gnt_type = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (grant[i]) begin
                gnt_id   = 4'(i);
                gnt_addr = rd_addr[32*i +: 32];
                gnt_type = rd_type[3*i +: 3];
            end
        end
    end

    always_comb begin
        ar_state_d = ar_state_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_type_d  = ar_type_q;
        arvalid    = 1'b0;
        case (ar_state_q)
            AR_IDLE: if (ar_accept) begin
                ar_id_d    = gnt_id;
                ar_addr_d  = gnt_addr;
                ar_type_d  = gnt_type;
                ar_state_d = AR_SEND;
            end
            AR_SEND: begin
                arvalid = 1'b1;
                if (arready) ar_state_d = AR_IDLE;
            end
            default: ar_state_d = AR_IDLE;
        endcase
    end

    // rlast frees the requester; grants read the registered busy, so a re-grant lands a cycle later.
    always_comb begin
        rd_busy_d = rd_busy_q;
        ret_valid = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (aresetn && rvalid && rid == 4'(i)) begin
                ret_valid[i] = 1'b1;
                if (rlast) rd_busy_d[i] = 1'b0;
            end
            if (ar_hs && ar_id_q == 4'(i)) rd_busy_d[i] = 1'b1;
        end
    end

    assign ret_last = aresetn && rvalid && rlast;
    assign ret_data = aresetn ? rdata : '0;
    assign rready   = aresetn;

    assign arid    = ar_id_q;
    assign araddr  = ar_addr_q;
    assign arlen   = ax_len(ar_type_q, LINE_WORDS);
    assign arsize  = ax_size(ar_type_q);
    assign arburst = aresetn ? BURST_INCR : '0;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        case (w_state_q)
            W_IDLE: if (w_accept) w_state_d = W_ADDR;
            W_ADDR: begin
                awvalid = 1'b1;
                if (awready) begin
                    w_cnt_d   = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wvalid = 1'b1;
                if (wready) begin
                    if (w_cnt_q == awlen) w_state_d = W_RESP;
                    else                  w_cnt_d   = w_cnt_q + 8'd1;
                end
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign awid    = aresetn ? 4'(NUM_RD) : '0;
    assign wid     = aresetn ? 4'(NUM_RD) : '0;
    assign awaddr  = w_addr_q;
    assign awlen   = ax_len(w_type_q, LINE_WORDS);
    assign awsize  = ax_size(w_type_q);
    assign awburst = aresetn ? BURST_INCR : '0;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;
    assign wdata   = is_line(w_type_q) ? w_words_q[w_cnt_q[WIDX-1:0]] : w_words_q[0];
    assign wstrb   = is_line(w_type_q) ? 4'hf : w_strb_q;
    assign wlast   = (w_state_q == W_DATA) && (w_cnt_q == awlen);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_state_q <= AR_IDLE;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_type_q  <= '0;
            rd_busy_q  <= '0;
            w_state_q  <= W_IDLE;
            w_cnt_q    <= '0;
        end else begin
            ar_state_q <= ar_state_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_type_q  <= ar_type_d;
            rd_busy_q  <= rd_busy_d;
            w_state_q  <= w_state_d;
            w_cnt_q    <= w_cnt_d;
        end
    end

    // Write payload is captured whole on acceptance and replayed beat by beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_addr_q <= '0;
            w_type_q <= '0;
            w_strb_q <= '0;
            for (int unsigned i = 0; i < LINE_WORDS; i++) w_words_q[i] <= '0;
        end else if (w_accept) begin
            w_addr_q <= wr_addr;
            w_type_q <= wr_type;
            w_strb_q <= wr_wstrb;
            for (int unsigned i = 0; i < LINE_WORDS; i++) w_words_q[i] <= wr_data[32*i +: 32];
        end
    end

`ifdef AXI_BRIDGE_PERF_CNT_EN
    logic [31:0] perf_rd_q, perf_wr_q, perf_stall_q;
    logic        stall;

    assign stall = |(rd_req & (rd_busy_q | hazard));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            perf_rd_q    <= '0;
            perf_wr_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_rd_q    <= perf_rd_q + 32'(ar_hs);
            perf_wr_q    <= perf_wr_q + 32'(bready && bvalid);
            perf_stall_q <= perf_stall_q + 32'(stall);
        end
    end

    assign perf_rd_cnt    = perf_rd_q;
    assign perf_wr_cnt    = perf_wr_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    assign perf_rd_cnt    = '0;
    assign perf_wr_cnt    = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_cache_bridge.sv
// Directed bench for axi_cache_bridge: slave side is driven step by step from a single initial block.
module tb_axi_cache_bridge;
    localparam int unsigned NUM_RD     = 3;
    localparam int unsigned LINE_WORDS = 4;

    logic                     aclk = 1'b0;
    logic                     aresetn;
    logic [NUM_RD-1:0]        rd_req;
    logic [3*NUM_RD-1:0]      rd_type;
    logic [32*NUM_RD-1:0]     rd_addr;
    logic [NUM_RD-1:0]        rd_rdy, ret_valid;
    logic                     ret_last;
    logic [31:0]              ret_data;
    logic                     wr_req;
    logic [2:0]               wr_type;
    logic [31:0]              wr_addr;
    logic [3:0]               wr_wstrb;
    logic [32*LINE_WORDS-1:0] wr_data;
    logic                     wr_rdy;
    logic [3:0]               arid, arcache, awid, awcache, wid, wstrb, rid, bid;
    logic [31:0]              araddr, awaddr, wdata, rdata;
    logic [7:0]               arlen, awlen;
    logic [2:0]               arsize, arprot, awsize, awprot;
    logic [1:0]               arburst, arlock, awburst, awlock, rresp, bresp;
    logic                     arvalid, arready, rlast, rvalid, rready;
    logic                     awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [31:0]              perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;

    int checks = 0;
    int errors = 0;

    axi_cache_bridge #(.NUM_RD(NUM_RD), .LINE_WORDS(LINE_WORDS), .LINE_OFF(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic rbeat(input string tag, input logic [3:0] id, input logic [31:0] d,
                         input logic l, input logic [2:0] exp_rdy);
        logic [2:0] exp_v;
        exp_v  = 3'b001 << id;
        rvalid = 1'b1; rid = id; rdata = d; rlast = l;
        #1;
        chk({tag, "_valid"}, 64'(ret_valid), 64'(exp_v));
        chk({tag, "_data"},  64'(ret_data),  64'(d));
        chk({tag, "_last"},  64'(ret_last),  64'(l));
        chk({tag, "_rdy"},   64'(rd_rdy),    64'(exp_rdy));
        cyc();
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0;
        rd_req = '0; rd_type = '0; rd_addr = '0;
        wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;

        // Reset state
        #12;
        chk("rst_wr_rdy",  64'(wr_rdy),  64'd0);
        chk("rst_rready",  64'(rready),  64'd0);
        chk("rst_arburst", 64'(arburst), 64'd0);
        chk("rst_awid",    64'(awid),    64'd0);
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_perf",    64'({perf_rd_cnt, perf_wr_cnt}), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        cyc();
        chk("rel_wr_rdy",  64'(wr_rdy),  64'd1);
        chk("rel_rready",  64'(rready),  64'd1);
        chk("rel_arburst", 64'(arburst), 64'd1);
        chk("rel_awid",    64'(awid),    64'd3);
        chk("rel_wid",     64'(wid),     64'd3);

        // Line reads on ports 0 and 2 together; port 0 keeps requesting while busy
        rd_type = {3'b100, 3'b000, 3'b100};
        rd_addr = {32'h0000_3000, 32'h0, 32'h0000_2000};
        rd_req  = 3'b101;
        #1;
        chk("t2_grant0", 64'(rd_rdy), 64'h1);
        cyc();
        chk("t2_ar0_valid", 64'(arvalid), 64'd1);
        chk("t2_ar0_id",    64'(arid),    64'd0);
        chk("t2_ar0_addr",  64'(araddr),  64'h2000);
        chk("t2_ar0_len",   64'(arlen),   64'd3);
        chk("t2_ar0_size",  64'(arsize),  64'd2);
        chk("t2_send_rdy",  64'(rd_rdy),  64'h0);
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        #1;
        chk("t5_other_granted", 64'(rd_rdy), 64'h4);
        cyc();
        rd_req = 3'b001;
        #1;
        chk("t2_ar2_id",   64'(arid),   64'd2);
        chk("t2_ar2_addr", 64'(araddr), 64'h3000);
        chk("t2_ar2_len",  64'(arlen),  64'd3);
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        rbeat("t2_b0", 4'd2, 32'hA0, 1'b0, 3'b000);
        rbeat("t2_b1", 4'd0, 32'hB0, 1'b0, 3'b000);
        rbeat("t2_b2", 4'd2, 32'hA1, 1'b0, 3'b000);
        rbeat("t2_b3", 4'd0, 32'hB1, 1'b0, 3'b000);
        rbeat("t2_b4", 4'd2, 32'hA2, 1'b0, 3'b000);
        rbeat("t2_b5", 4'd2, 32'hA3, 1'b1, 3'b000);
        rbeat("t2_b6", 4'd0, 32'hB2, 1'b0, 3'b000);
        rbeat("t5_last_no_grant", 4'd0, 32'hB3, 1'b1, 3'b000);
        #1;
        chk("t5_regrant", 64'(rd_rdy), 64'h1);
        rd_req = 3'b000;
        cyc();

        // Single word read on port 1
        rd_type = {3'b000, 3'b010, 3'b000};
        rd_addr = {32'h0, 32'h1c00_0004, 32'h0};
        rd_req  = 3'b010;
        #1;
        chk("t1_rdy", 64'(rd_rdy), 64'h2);
        cyc();
        rd_req = 3'b000;
        #1;
        chk("t1_arvalid", 64'(arvalid), 64'd1);
        chk("t1_arid",    64'(arid),    64'd1);
        chk("t1_araddr",  64'(araddr),  64'h1c00_0004);
        chk("t1_arlen",   64'(arlen),   64'd0);
        chk("t1_arsize",  64'(arsize),  64'd2);
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        #1;
        chk("t1_ar_done", 64'(arvalid), 64'd0);
        rbeat("t1_ret", 4'd1, 32'h1234_5678, 1'b1, 3'b000);

        // Line write racing a same-line read; read held until the write completes
        wr_req  = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_1000;
        wr_data = {32'h44, 32'h33, 32'h22, 32'h11};
        rd_addr = {32'h0, 32'h0000_100c, 32'h0};
        rd_req  = 3'b010;
        #1;
        chk("t3_wr_rdy",    64'(wr_rdy), 64'd1);
        chk("t3_same_cycle", 64'(rd_rdy), 64'h0);
        cyc();
        wr_req = 1'b0;
        #1;
        chk("t3_awvalid", 64'(awvalid), 64'd1);
        chk("t3_awaddr",  64'(awaddr),  64'h1000);
        chk("t3_awlen",   64'(awlen),   64'd3);
        chk("t3_awsize",  64'(awsize),  64'd2);
        chk("t3_addr_rdy", 64'(rd_rdy), 64'h0);
        awready = 1'b1;
        cyc();
        awready = 1'b0;
        wready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_wdata", 64'(wdata),  64'(32'h11 * (k + 1)));
            chk("t3_wstrb", 64'(wstrb),  64'hf);
            chk("t3_wlast", 64'(wlast),  64'(k == 3));
            chk("t3_d_rdy", 64'(rd_rdy), 64'h0);
            cyc();
        end
        wready = 1'b0;
        #1;
        chk("t3_bready", 64'(bready), 64'd1);
        chk("t3_wvalid", 64'(wvalid), 64'd0);
        cyc();
        chk("t3_resp_rdy", 64'(rd_rdy), 64'h0);
        bvalid = 1'b1;
        #1;
        chk("t3_bvalid_rdy", 64'(rd_rdy), 64'h0);
        cyc();
        bvalid = 1'b0;
        #1;
        chk("t3_after_b_rdy", 64'(rd_rdy), 64'h2);
        cyc();
        rd_req = 3'b000;
        #1;
        chk("t3_ar_addr", 64'(araddr), 64'h100c);
        chk("t3_ar_id",   64'(arid),   64'd1);
        arready = 1'b1;
        cyc();
        arready = 1'b0;
`ifdef AXI_BRIDGE_PERF_CNT_EN
        chk("perf_rd", 64'(perf_rd_cnt), 64'd4);
        chk("perf_wr", 64'(perf_wr_cnt), 64'd1);
`else
        chk("perf_rd", 64'(perf_rd_cnt), 64'd0);
        chk("perf_wr", 64'(perf_wr_cnt), 64'd0);
`endif
        rbeat("t3_ret", 4'd1, 32'hCAFE_F00D, 1'b1, 3'b000);

        // Byte write
        wr_req = 1'b1; wr_type = 3'b000; wr_addr = 32'h0000_2002; wr_wstrb = 4'b0100;
        wr_data = {96'h0, 32'h00AB_0000};
        #1;
        chk("t4_wr_rdy", 64'(wr_rdy), 64'd1);
        cyc();
        wr_req = 1'b0;
        #1;
        chk("t4_awaddr", 64'(awaddr), 64'h2002);
        chk("t4_awlen",  64'(awlen),  64'd0);
        chk("t4_awsize", 64'(awsize), 64'd0);
        awready = 1'b1;
        cyc();
        awready = 1'b0;
        #1;
        chk("t4_wvalid", 64'(wvalid), 64'd1);
        chk("t4_wdata",  64'(wdata),  64'h00AB_0000);
        chk("t4_wstrb",  64'(wstrb),  64'h4);
        chk("t4_wlast",  64'(wlast),  64'd1);
        wready = 1'b1;
        cyc();
        wready = 1'b0;
        bvalid = 1'b1;
        #1;
        chk("t4_bready", 64'(bready), 64'd1);
        cyc();
        bvalid = 1'b0;
        #1;
        chk("t4_idle", 64'(wr_rdy), 64'd1);

        // Reset asserted mid W_DATA
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_4000;
        wr_data = {32'hDD, 32'hCC, 32'hBB, 32'hAA};
        cyc();
        wr_req  = 1'b0;
        awready = 1'b1;
        cyc();
        awready = 1'b0;
        wready  = 1'b1;
        #1;
        chk("t6_beat0", 64'(wdata), 64'hAA);
        cyc();
        chk("t6_beat1", 64'(wdata), 64'hBB);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_wvalid", 64'(wvalid), 64'd0);
        chk("t6_rst_wr_rdy", 64'(wr_rdy), 64'd0);
        chk("t6_rst_wdata",  64'(wdata),  64'd0);
        chk("t6_rst_wstrb",  64'(wstrb),  64'd0);
        chk("t6_rst_wlast",  64'(wlast),  64'd0);
        chk("t6_rst_awid",   64'(awid),   64'd0);
        chk("t6_rst_rready", 64'(rready), 64'd0);
        wready = 1'b0;
        cyc();
        aresetn = 1'b1;
        #1;
        chk("t6_rel_wr_rdy",  64'(wr_rdy),  64'd1);
        chk("t6_rel_wvalid",  64'(wvalid),  64'd0);
        chk("t6_rel_awvalid", 64'(awvalid), 64'd0);
        chk("t6_perf", 64'({perf_rd_cnt, perf_wr_cnt}), 64'd0);
        chk("t6_perf_stall", 64'(perf_stall_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
